led_pwm_pio: RTL and testbench

Parametrised Avalon-MM LED/PIO output peripheral for the Nios II system, the successor to the fixed 8-bit LED export. Each of NUM_CH outputs is independently either a direct register bit or a PWM channel with glitch-free duty update. A shared prescaler sets the PWM period. The block sits on the system interconnect as an Avalon-MM slave and drives the board LEDs.

---
 rtl/led_pwm_pio_if.sv | 24 ++
 rtl/led_pwm_pio.sv | 162 ++++++++++++++++
 tb/tb_led_pwm_pio.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/led_pwm_pio_if.sv
// Avalon-MM slave bus bundle for led_pwm_pio: word address, write, read, and read data with a fixed latency of 1.
interface led_pwm_pio_if;
    logic [3:0]  avs_address;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic        avs_read;
    logic [31:0] avs_readdata;

    modport slave (
        input  avs_address,
        input  avs_write,
        input  avs_writedata,
        input  avs_read,
        output avs_readdata
    );

    modport master (
        output avs_address,
        output avs_write,
        output avs_writedata,
        output avs_read,
        input  avs_readdata
    );
endinterface

// File: rtl/led_pwm_pio.sv
// Avalon-MM LED/PIO peripheral. Each channel drives either a direct register bit or a PWM output with shadowed duty.
// Optional LED_PWM_FADE_EN: at each period start the active duty steps one count toward its target.
module led_pwm_pio #(
    parameter int NUM_CH        = 8,
    parameter int PWM_BITS      = 8,
    parameter int PRESCALE_BITS = 16
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    led_pwm_pio_if.slave      avs,
    output logic [NUM_CH-1:0] leds_export
);

    localparam logic [PWM_BITS-1:0]      PWM_LAST = {{(PWM_BITS-1){1'b1}}, 1'b0};
    localparam logic [PWM_BITS-1:0]      PWM_ONE  = PWM_BITS'(1);
    localparam logic [PRESCALE_BITS-1:0] PRE_ONE  = PRESCALE_BITS'(1);
    localparam int                       ADDR_DUTY0 = 4;

    logic [NUM_CH-1:0]        out_q;
    logic [NUM_CH-1:0]        mode_q;
    logic [NUM_CH-1:0]        leds_q;
    logic [PRESCALE_BITS-1:0] prescale_q;
    logic [PRESCALE_BITS-1:0] pre_cnt_q;
    logic [PWM_BITS-1:0]      pwm_cnt_q;
    logic [15:0]              status_q;
    logic [PWM_BITS-1:0]      target_q [NUM_CH];
    logic [PWM_BITS-1:0]      active_q [NUM_CH];
    logic [PWM_BITS-1:0]      active_d [NUM_CH];
    logic [31:0]              readdata_q;
    logic [31:0]              readdata_d;

    logic              tick;
    logic              period_start;
    logic              wr_out;
    logic              wr_mode;
    logic              wr_prescale;
    logic [NUM_CH-1:0] duty_we;
    logic [NUM_CH-1:0] pwm;
    logic              unused_wdata;

    assign unused_wdata = ^avs.avs_writedata;

    assign tick         = (pre_cnt_q == prescale_q);
    assign period_start = tick && (pwm_cnt_q == PWM_LAST);

    always_comb begin
        wr_out      = avs.avs_write && (avs.avs_address == 4'd0);
        wr_mode     = avs.avs_write && (avs.avs_address == 4'd1);
        wr_prescale = avs.avs_write && (avs.avs_address == 4'd2);
        duty_we     = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            duty_we[ch] = avs.avs_write && (avs.avs_address == 4'(ADDR_DUTY0 + ch));
        end
    end

    // Active duty only changes at period start, so a running period is never cut short or stretched.
    always_comb begin
        for (int ch = 0; ch < NUM_CH; ch++) begin
`ifdef LED_PWM_FADE_EN
            active_d[ch] = active_q[ch];
            if (active_q[ch] < target_q[ch]) begin
                active_d[ch] = active_q[ch] + PWM_ONE;
            end else if (active_q[ch] > target_q[ch]) begin
                active_d[ch] = active_q[ch] - PWM_ONE;
            end
`else
            active_d[ch] = target_q[ch];
`endif
            pwm[ch] = (pwm_cnt_q < active_q[ch]);
        end
    end

`ifdef LED_PWM_FADE_EN
    logic fading;
    always_comb begin
        fading = 1'b0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (active_q[ch] != target_q[ch]) begin
                fading = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        readdata_d = '0;
        case (avs.avs_address)
            4'd0: readdata_d[NUM_CH-1:0]        = out_q;
            4'd1: readdata_d[NUM_CH-1:0]        = mode_q;
            4'd2: readdata_d[PRESCALE_BITS-1:0] = prescale_q;
            4'd3: begin
                readdata_d[15:0] = status_q;
`ifdef LED_PWM_FADE_EN
                readdata_d[16]   = fading;
`endif
            end
            default: begin
                for (int ch = 0; ch < NUM_CH; ch++) begin
                    if (avs.avs_address == 4'(ADDR_DUTY0 + ch)) begin
                        readdata_d[PWM_BITS-1:0] = target_q[ch];
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            out_q      <= '0;
            mode_q     <= '0;
            leds_q     <= '0;
            prescale_q <= '0;
            pre_cnt_q  <= '0;
            pwm_cnt_q  <= '0;
            status_q   <= '0;
            readdata_q <= '0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                target_q[ch] <= '0;
                active_q[ch] <= '0;
            end
        end else begin
            if (wr_out)      out_q      <= avs.avs_writedata[NUM_CH-1:0];
            if (wr_mode)     mode_q     <= avs.avs_writedata[NUM_CH-1:0];
            if (wr_prescale) prescale_q <= avs.avs_writedata[PRESCALE_BITS-1:0];

            // A PRESCALE write restarts the tick interval but leaves the PWM phase alone.
            if (wr_prescale || tick) begin
                pre_cnt_q <= '0;
            end else begin
                pre_cnt_q <= pre_cnt_q + PRE_ONE;
            end

            if (tick) begin
                pwm_cnt_q <= (pwm_cnt_q == PWM_LAST) ? '0 : pwm_cnt_q + PWM_ONE;
            end
            if (period_start) begin
                status_q <= status_q + 16'd1;
            end

            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (duty_we[ch]) begin
                    target_q[ch] <= avs.avs_writedata[PWM_BITS-1:0];
                end
                if (period_start) begin
                    active_q[ch] <= active_d[ch];
                end
            end

            if (avs.avs_read) begin
                readdata_q <= readdata_d;
            end

            for (int ch = 0; ch < NUM_CH; ch++) begin
                leds_q[ch] <= mode_q[ch] ? pwm[ch] : out_q[ch];
            end
        end
    end

    assign avs.avs_readdata = readdata_q;
    assign leds_export      = leds_q;

endmodule

// File: tb/tb_led_pwm_pio.sv
// Directed, table-driven bench for led_pwm_pio (NUM_CH=8, PWM_BITS=8, PRESCALE_BITS=16).
// Drives the bus on falling edges and samples outputs on falling edges.
module tb_led_pwm_pio;

    localparam int NUM_CH        = 8;
    localparam int PWM_BITS      = 8;
    localparam int PRESCALE_BITS = 16;

    logic              clk_clk       = 1'b0;
    logic              reset_reset_n = 1'b0;
    logic [NUM_CH-1:0] leds_export;

    led_pwm_pio_if avs_bus ();

    led_pwm_pio #(
        .NUM_CH        (NUM_CH),
        .PWM_BITS      (PWM_BITS),
        .PRESCALE_BITS (PRESCALE_BITS)
    ) dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .avs           (avs_bus),
        .leds_export   (leds_export)
    );

    always #5 clk_clk = ~clk_clk;

    // Rising edges since the last reset release; equals k at the falling edge after edge k.
    int edgeCount;
    always @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) edgeCount <= 0;
        else                edgeCount <= edgeCount + 1;
    end

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [31:0] expRead;
        logic [7:0]  expLeds;
    } vec_t;

    vec_t vecs [12];
    int   vecCount  = 0;
    int   missCount = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vecCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic busIdle();
        avs_bus.avs_address   = 4'd0;
        avs_bus.avs_write     = 1'b0;
        avs_bus.avs_writedata = 32'd0;
        avs_bus.avs_read      = 1'b0;
    endtask

    task automatic applyStimulus(input logic [3:0] addr, input logic [31:0] data);
        @(negedge clk_clk);
        avs_bus.avs_address   = addr;
        avs_bus.avs_writedata = data;
        avs_bus.avs_write     = 1'b1;
        @(negedge clk_clk);
        busIdle();
    endtask

    task automatic busRead(input logic [3:0] addr, output logic [31:0] data);
        avs_bus.avs_address = addr;
        avs_bus.avs_read    = 1'b1;
        @(negedge clk_clk);
        busIdle();
        data = avs_bus.avs_readdata;
    endtask

    task automatic applyReset();
        busIdle();
        reset_reset_n = 1'b0;
        repeat (3) @(negedge clk_clk);
        reset_reset_n = 1'b1;
    endtask

    task automatic readStatusAfter(input int k, output logic [31:0] data);
        while (edgeCount < k) @(negedge clk_clk);
        busRead(4'd3, data);
    endtask

    task automatic waitRise(input int bitIdx, input int bound, output logic found);
        int n = 0;
        while (leds_export[bitIdx] !== 1'b1 && n < bound) begin
            @(negedge clk_clk);
            n++;
        end
        found = (leds_export[bitIdx] === 1'b1);
    endtask

    task automatic countHigh(input int bitIdx, input int cycles, output int highs);
        highs = 0;
        for (int i = 0; i < cycles; i++) begin
            if (leds_export[bitIdx] === 1'b1) highs++;
            @(negedge clk_clk);
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic        found;
        int          highs;

        vecs[0]  = '{4'd2,  32'hABCD_1234, 32'h0000_1234, 8'h00};
        vecs[1]  = '{4'd0,  32'hFFFF_FFFF, 32'h0000_00FF, 8'hFF};
        vecs[2]  = '{4'd0,  32'h0000_00A5, 32'h0000_00A5, 8'hA5};
        vecs[3]  = '{4'd1,  32'hFFFF_FF00, 32'h0000_0000, 8'hA5};
        vecs[4]  = '{4'd3,  32'hFFFF_FFFF, 32'h0000_0000, 8'hA5};
        vecs[5]  = '{4'd4,  32'hFFFF_FF40, 32'h0000_0040, 8'hA5};
        vecs[6]  = '{4'd11, 32'h0000_0123, 32'h0000_0023, 8'hA5};
        vecs[7]  = '{4'd12, 32'hFFFF_FFFF, 32'h0000_0000, 8'hA5};
        vecs[8]  = '{4'd15, 32'hFFFF_FFFF, 32'h0000_0000, 8'hA5};
        vecs[9]  = '{4'd11, 32'h0000_0000, 32'h0000_0000, 8'hA5};
        vecs[10] = '{4'd4,  32'h0000_0000, 32'h0000_0000, 8'hA5};
        vecs[11] = '{4'd0,  32'h0000_003C, 32'h0000_003C, 8'h3C};

        busIdle();
        applyReset();

        // Everything reads back zero out of reset.
        @(negedge clk_clk);
        checkOutput("reset_leds", 32'(leds_export), 32'h0);
        for (int a = 0; a < 16; a++) begin
            busRead(4'(a), rd);
            checkOutput($sformatf("reset_read_addr%0d", a), rd, 32'h0);
        end

        for (int v = 0; v < 12; v++) begin
            applyStimulus(vecs[v].addr, vecs[v].wdata);
            busRead(vecs[v].addr, rd);
            checkOutput($sformatf("vec%0d_read", v), rd, vecs[v].expRead);
            checkOutput($sformatf("vec%0d_leds", v), 32'(leds_export), 32'(vecs[v].expLeds));
        end

        // OUT write reaches leds one edge after the register update.
        @(negedge clk_clk);
        avs_bus.avs_address   = 4'd0;
        avs_bus.avs_writedata = 32'h0000_00A5;
        avs_bus.avs_write     = 1'b1;
        @(negedge clk_clk);
        busIdle();
        checkOutput("out_leds_first_edge", 32'(leds_export), 32'h3C);
        @(negedge clk_clk);
        checkOutput("out_leds_second_edge", 32'(leds_export), 32'hA5);

        // Read and write to the same address in one cycle returns the old value.
        avs_bus.avs_address   = 4'd0;
        avs_bus.avs_writedata = 32'h0000_005A;
        avs_bus.avs_write     = 1'b1;
        avs_bus.avs_read      = 1'b1;
        @(negedge clk_clk);
        busIdle();
        checkOutput("rw_same_addr_old", avs_bus.avs_readdata, 32'h0000_00A5);
        busRead(4'd0, rd);
        checkOutput("rw_same_addr_new", rd, 32'h0000_005A);

        // PRESCALE=3 written on the first edge after reset: period starts land on edges 1017 and 2037.
        busIdle();
        reset_reset_n = 1'b0;
        repeat (3) @(negedge clk_clk);
        reset_reset_n         = 1'b1;
        avs_bus.avs_address   = 4'd2;
        avs_bus.avs_writedata = 32'd3;
        avs_bus.avs_write     = 1'b1;
        @(negedge clk_clk);
        busIdle();
        readStatusAfter(1010, rd);
        checkOutput("status_before_first", rd, 32'd0);
        readStatusAfter(1025, rd);
        checkOutput("status_after_first", rd, 32'd1);
        readStatusAfter(2030, rd);
        checkOutput("status_before_second", rd, 32'd1);
        readStatusAfter(2040, rd);
        checkOutput("status_after_second", rd, 32'd2);

`ifndef LED_PWM_FADE_EN
        // Channel 0 PWM at duty 64, then the duty extremes.
        applyReset();
        applyStimulus(4'd1, 32'h01);
        applyStimulus(4'd4, 32'd64);
        waitRise(0, 600, found);
        checkOutput("pwm64_rise_seen", 32'(found), 32'd1);
        countHigh(0, 255, highs);
        checkOutput("pwm64_period1_high", 32'(highs), 32'd64);
        countHigh(0, 255, highs);
        checkOutput("pwm64_period2_high", 32'(highs), 32'd64);

        applyStimulus(4'd4, 32'd0);
        repeat (600) @(negedge clk_clk);
        countHigh(0, 255, highs);
        checkOutput("pwm0_high", 32'(highs), 32'd0);

        applyStimulus(4'd4, 32'd255);
        repeat (600) @(negedge clk_clk);
        countHigh(0, 255, highs);
        checkOutput("pwm255_high", 32'(highs), 32'd255);

        // DUTY1 rewritten mid-high: current period keeps 64, next period uses 128.
        applyReset();
        applyStimulus(4'd1, 32'h02);
        applyStimulus(4'd5, 32'd64);
        waitRise(1, 600, found);
        checkOutput("ch1_rise_seen", 32'(found), 32'd1);
        highs = 0;
        for (int i = 0; i < 255; i++) begin
            if (leds_export[1] === 1'b1) highs++;
            if (i == 10) begin
                avs_bus.avs_address   = 4'd5;
                avs_bus.avs_writedata = 32'd128;
                avs_bus.avs_write     = 1'b1;
            end else begin
                busIdle();
            end
            @(negedge clk_clk);
        end
        checkOutput("ch1_midwrite_old_period", 32'(highs), 32'd64);
        countHigh(1, 255, highs);
        checkOutput("ch1_midwrite_new_period", 32'(highs), 32'd128);
        busRead(4'd3, rd);
        checkOutput("status_fade_bit_off", 32'(rd[16]), 32'd0);
`else
        // Fade 0 -> 4 on channel 0: one step per period, flag clears once reached.
        applyReset();
        applyStimulus(4'd1, 32'h01);
        applyStimulus(4'd4, 32'd4);
        waitRise(0, 600, found);
        checkOutput("fade_rise_seen", 32'(found), 32'd1);
        busRead(4'd3, rd);
        checkOutput("fade_flag_set", 32'(rd[16]), 32'd1);
        countHigh(0, 254, highs);
        checkOutput("fade_step1_rest", 32'(highs), 32'd0);
        countHigh(0, 255, highs);
        checkOutput("fade_step2_high", 32'(highs), 32'd2);
        countHigh(0, 255, highs);
        checkOutput("fade_step3_high", 32'(highs), 32'd3);
        countHigh(0, 255, highs);
        checkOutput("fade_step4_high", 32'(highs), 32'd4);
        busRead(4'd3, rd);
        checkOutput("fade_flag_clear", 32'(rd[16]), 32'd0);
`endif

        // Asynchronous reset drops the outputs between clock edges and restarts the period count.
        applyReset();
        applyStimulus(4'd0, 32'hFF);
        readStatusAfter(600, rd);
        checkOutput("status_before_reset", rd, 32'd2);
        checkOutput("leds_before_reset", 32'(leds_export), 32'hFF);
        @(negedge clk_clk);
        #2 reset_reset_n = 1'b0;
        #1 checkOutput("leds_async_reset", 32'(leds_export), 32'h0);
        repeat (2) @(negedge clk_clk);
        reset_reset_n = 1'b1;
        @(negedge clk_clk);
        busRead(4'd3, rd);
        checkOutput("status_after_reset", rd, 32'd0);
        busRead(4'd0, rd);
        checkOutput("out_after_reset", rd, 32'd0);
        checkOutput("leds_after_reset", 32'(leds_export), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
